// File: rtl/mips_pkg.sv
// mips_pkg: shared writeback-select and load-size encodings plus default widths
package mips_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_RADDR_W = 5;
  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_LINK = 2'd2;
  localparam logic [1:0] LD_WORD = 2'd0;
  localparam logic [1:0] LD_HALF = 2'd1;
  localparam logic [1:0] LD_BYTE = 2'd2;
endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: MEM-stage inputs, pipeline control and writeback outputs of the MEM/WB register
interface mem_wb_stage_if import mips_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RADDR_W = DEF_RADDR_W,
  parameter int CNT_W = 32
);
  logic em_valid;
  logic em_reg_write;
  logic [1:0] em_wb_sel;
  logic [1:0] em_ld_size;
  logic em_ld_signed;
  logic [DATA_W-1:0] em_alu_result;
  logic [DATA_W-1:0] em_read_data;
  logic [DATA_W-1:0] em_pc_plus4;
  logic [RADDR_W-1:0] em_wb_addr;
  logic stall;
  logic flush;
  logic mw_valid;
  logic mw_reg_write;
  logic [RADDR_W-1:0] mw_wb_addr;
  logic [DATA_W-1:0] mw_wb_data;
  logic [CNT_W-1:0] retired;
  modport master (
    output em_valid, em_reg_write, em_wb_sel, em_ld_size, em_ld_signed, em_alu_result,
           em_read_data, em_pc_plus4, em_wb_addr, stall, flush,
    input mw_valid, mw_reg_write, mw_wb_addr, mw_wb_data, retired
  );
  modport slave (
    input em_valid, em_reg_write, em_wb_sel, em_ld_size, em_ld_signed, em_alu_result,
          em_read_data, em_pc_plus4, em_wb_addr, stall, flush,
    output mw_valid, mw_reg_write, mw_wb_addr, mw_wb_data, retired
  );
endinterface

// File: rtl/mem_wb_stage_load_extract.sv
// load_extract: big-endian sub-word select of the low 32-bit memory word with zero/sign extension
module load_extract import mips_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [1:0]        ld_size,
  input  logic              ld_signed,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] data
);
  logic [31:0] word;
  logic [7:0] b;
  logic [15:0] h;
  logic [DATA_W-1:0] bx;
  logic [DATA_W-1:0] hx;
  // offset 0 is the most significant lane, as on a big-endian MIPS bus
  always_comb begin
    word = 32'(read_data);
    b = offset == 2'd0 ? word[31:24] : offset == 2'd1 ? word[23:16] : offset == 2'd2 ? word[15:8] : word[7:0];
    h = offset[1] ? word[15:0] : word[31:16];
    bx = ld_signed ? DATA_W'($signed(b)) : DATA_W'(b);
    hx = ld_signed ? DATA_W'($signed(h)) : DATA_W'(h);
    data = ld_size == LD_HALF ? hx : ld_size == LD_BYTE ? bx : read_data;
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with writeback mux, stall/flush and retire counter; MEM_WB_LDEXT_EN enables sub-word load extraction
module mem_wb_stage import mips_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RADDR_W = DEF_RADDR_W,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  mem_wb_stage_if.slave bus
);
  logic valid_d, valid_q;
  logic reg_write_d, reg_write_q;
  logic [RADDR_W-1:0] wb_addr_d, wb_addr_q;
  logic [DATA_W-1:0] wb_data_d, wb_data_q;
  logic [CNT_W-1:0] retired_d, retired_q;
  logic [DATA_W-1:0] mem_data;
  logic hold;
`ifdef MEM_WB_LDEXT_EN
  load_extract #(.DATA_W(DATA_W)) u_load_extract (
    .ld_size(bus.em_ld_size),
    .ld_signed(bus.em_ld_signed),
    .offset(bus.em_alu_result[1:0]),
    .read_data(bus.em_read_data),
    .data(mem_data)
  );
`else
  assign mem_data = bus.em_read_data;
`endif
  // flush beats stall; a flush keeps address/data but kills valid and write enable
  always_comb begin
    hold = bus.flush | bus.stall;
    valid_d = bus.flush ? 1'b0 : bus.stall ? valid_q : bus.em_valid;
    reg_write_d = bus.flush ? 1'b0 : bus.stall ? reg_write_q
                : bus.em_valid & bus.em_reg_write & (bus.em_wb_addr != '0);
    wb_addr_d = hold ? wb_addr_q : bus.em_wb_addr;
    wb_data_d = hold ? wb_data_q
              : bus.em_wb_sel == WB_SEL_LINK ? bus.em_pc_plus4
              : bus.em_wb_sel == WB_SEL_MEM ? mem_data : bus.em_alu_result;
    retired_d = hold ? retired_q : retired_q + CNT_W'(bus.em_valid);
  end
  // stage registers; reset discards whatever instruction is held
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      reg_write_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      retired_q <= '0;
    end else begin
      valid_q <= valid_d;
      reg_write_q <= reg_write_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      retired_q <= retired_d;
    end
  end
  assign bus.mw_valid = valid_q;
  assign bus.mw_reg_write = reg_write_q;
  assign bus.mw_wb_addr = wb_addr_q;
  assign bus.mw_wb_data = wb_data_q;
  assign bus.retired = retired_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed checks of mem_wb_stage, with a 4-bit-counter copy for wrap
module tb_mem_wb_stage;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mem_wb_stage_if bus ();
  mem_wb_stage_if #(.CNT_W(4)) bw ();
  mem_wb_stage u_dut (.clk(clk), .rst(rst), .bus(bus));
  mem_wb_stage #(.CNT_W(4)) u_dut_w (.clk(clk), .rst(rst), .bus(bw));
  assign bw.em_valid = bus.em_valid;
  assign bw.em_reg_write = bus.em_reg_write;
  assign bw.em_wb_sel = bus.em_wb_sel;
  assign bw.em_ld_size = bus.em_ld_size;
  assign bw.em_ld_signed = bus.em_ld_signed;
  assign bw.em_alu_result = bus.em_alu_result;
  assign bw.em_read_data = bus.em_read_data;
  assign bw.em_pc_plus4 = bus.em_pc_plus4;
  assign bw.em_wb_addr = bus.em_wb_addr;
  assign bw.stall = bus.stall;
  assign bw.flush = bus.flush;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [1:0] sel, input logic [31:0] alu, input logic [4:0] addr);
    bus.em_valid = 1'b1;
    bus.em_reg_write = 1'b1;
    bus.em_wb_sel = sel;
    bus.em_alu_result = alu;
    bus.em_wb_addr = addr;
  endtask

  logic [1:0] ld_size [4] = '{2'd2, 2'd2, 2'd1, 2'd1};
  logic ld_sgn [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [1:0] ld_off [4] = '{2'd0, 2'd3, 2'd2, 2'd0};
`ifdef MEM_WB_LDEXT_EN
  logic [31:0] ld_exp [4] = '{32'hFFFF_FF80, 32'h0000_0001, 32'h0000_7F01, 32'hFFFF_80FF};
`else
  logic [31:0] ld_exp [4] = '{32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01};
`endif

  initial begin
    rst = 1'b1;
    bus.em_valid = 1'b0;
    bus.em_reg_write = 1'b0;
    bus.em_wb_sel = 2'd0;
    bus.em_ld_size = 2'd0;
    bus.em_ld_signed = 1'b0;
    bus.em_alu_result = '0;
    bus.em_read_data = '0;
    bus.em_pc_plus4 = '0;
    bus.em_wb_addr = '0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    step();
    step();
    chk("rst_valid", 64'(bus.mw_valid), 64'd0);
    chk("rst_rw", 64'(bus.mw_reg_write), 64'd0);
    chk("rst_addr", 64'(bus.mw_wb_addr), 64'd0);
    chk("rst_data", 64'(bus.mw_wb_data), 64'd0);
    chk("rst_retired", 64'(bus.retired), 64'd0);
    rst = 1'b0;
    op(2'd0, 32'h0000_1234, 5'd8);
    step();
    chk("alu_data", 64'(bus.mw_wb_data), 64'h1234);
    chk("alu_addr", 64'(bus.mw_wb_addr), 64'd8);
    chk("alu_rw", 64'(bus.mw_reg_write), 64'd1);
    chk("alu_valid", 64'(bus.mw_valid), 64'd1);
    chk("alu_retired", 64'(bus.retired), 64'd1);
    bus.em_read_data = 32'h80FF_7F01;
    for (int i = 0; i < 4; i++) begin
      op(2'd1, 32'h1000_0000 | 32'(ld_off[i]), 5'd3);
      bus.em_ld_size = ld_size[i];
      bus.em_ld_signed = ld_sgn[i];
      step();
      chk($sformatf("load%0d_data", i), 64'(bus.mw_wb_data), 64'(ld_exp[i]));
      chk($sformatf("load%0d_retired", i), 64'(bus.retired), 64'(i + 2));
    end
    bus.em_pc_plus4 = 32'h0040_0008;
    op(2'd2, 32'h0000_0abc, 5'd31);
    step();
    chk("link_data", 64'(bus.mw_wb_data), 64'h0040_0008);
    chk("link_rw", 64'(bus.mw_reg_write), 64'd1);
    op(2'd2, 32'h0000_0abc, 5'd0);
    step();
    chk("r0_rw", 64'(bus.mw_reg_write), 64'd0);
    chk("r0_valid", 64'(bus.mw_valid), 64'd1);
    chk("r0_retired", 64'(bus.retired), 64'd7);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op(2'd0, 32'h0000_dead + 32'(i), 5'd9 + 5'(i));
      step();
      chk($sformatf("stall%0d_data", i), 64'(bus.mw_wb_data), 64'h0040_0008);
      chk($sformatf("stall%0d_addr", i), 64'(bus.mw_wb_addr), 64'd0);
      chk($sformatf("stall%0d_valid", i), 64'(bus.mw_valid), 64'd1);
      chk($sformatf("stall%0d_retired", i), 64'(bus.retired), 64'd7);
    end
    op(2'd0, 32'h0000_beef, 5'd12);
    step();
    chk("pre_flush_rw", 64'(bus.mw_reg_write), 64'd0);
    bus.stall = 1'b0;
    op(2'd0, 32'h0000_beef, 5'd12);
    step();
    chk("pre_flush_rw1", 64'(bus.mw_reg_write), 64'd1);
    chk("pre_flush_retired", 64'(bus.retired), 64'd8);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    op(2'd0, 32'h0000_f00d, 5'd13);
    step();
    chk("flush_valid", 64'(bus.mw_valid), 64'd0);
    chk("flush_rw", 64'(bus.mw_reg_write), 64'd0);
    chk("flush_data", 64'(bus.mw_wb_data), 64'hbeef);
    chk("flush_addr", 64'(bus.mw_wb_addr), 64'd12);
    chk("flush_retired", 64'(bus.retired), 64'd8);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    op(2'd0, 32'h0000_0011, 5'd14);
    bus.em_valid = 1'b0;
    step();
    chk("bubble_rw", 64'(bus.mw_reg_write), 64'd0);
    chk("bubble_valid", 64'(bus.mw_valid), 64'd0);
    chk("bubble_retired", 64'(bus.retired), 64'd8);
    op(2'd0, 32'h0000_0055, 5'd5);
    step();
    chk("mid_pre_rw", 64'(bus.mw_reg_write), 64'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 64'(bus.mw_valid), 64'd0);
    chk("mid_rst_rw", 64'(bus.mw_reg_write), 64'd0);
    chk("mid_rst_addr", 64'(bus.mw_wb_addr), 64'd0);
    chk("mid_rst_data", 64'(bus.mw_wb_data), 64'd0);
    chk("mid_rst_retired", 64'(bus.retired), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      op(2'd0, 32'(i), 5'd1);
      step();
    end
    chk("wrap_retired4", 64'(bw.retired), 64'd1);
    chk("wrap_retired32", 64'(bus.retired), 64'd17);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
